// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel-stream constants, clog2 helper and frame marker bit indices
package pixel_pkg;

    localparam int PIX_DATA_W = 8;
    localparam int PIX_IMG_W  = 8;
    localparam int PIX_IMG_H  = 8;

    localparam int MARK_SOF = 0;
    localparam int MARK_EOL = 1;
    localparam int MARK_EOF = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// pixel_sync_fifo: first-word-fall-through synchronous FIFO with separately tracked occupancy
module pixel_sync_fifo
    import pixel_pkg::*;
#(
    parameter int DATA_W     = PIX_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign full  = level == DEPTH_L;
    assign empty = level == '0;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // pointers wrap naturally; level keeps full and empty distinct
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // storage needs no reset: dout is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_frame_packer.sv
// pixel_frame_packer: buffers a no-backpressure pixel stream and re-emits it ready/valid with sof/eol/eof
// Optional PIXEL_FRAME_PACKER_CHECKSUM_EN adds a per-frame 16-bit pixel sum on port checksum.
module pixel_frame_packer
    import pixel_pkg::*;
#(
    parameter int DATA_W     = PIX_DATA_W,
    parameter int IMG_W      = PIX_IMG_W,
    parameter int IMG_H      = PIX_IMG_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            pixel_in,
    input  logic                         valid_in,
    input  logic                         ready_in,
    output logic [DATA_W-1:0]            pixel_out,
    output logic                         valid_out,
    output logic                         sof,
    output logic                         eol,
    output logic                         eof,
    output logic                         frame_done,
    output logic                         overflow,
    output logic [clog2(FIFO_DEPTH):0]   level
`ifdef PIXEL_FRAME_PACKER_CHECKSUM_EN
    ,
    output logic [15:0]                  checksum
`endif
);

    localparam int CW = clog2(IMG_W + 1);
    localparam int RW = clog2(IMG_H + 1);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          last_col;
    logic          last_row;
    logic [2:0]    mark;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign valid_out = !empty;
    assign pop       = valid_out && ready_in;
    assign push      = valid_in && (!full || pop);

    assign last_col       = col == CW'(IMG_W - 1);
    assign last_row       = row == RW'(IMG_H - 1);
    assign mark[MARK_SOF] = col == '0 && row == '0;
    assign mark[MARK_EOL] = last_col;
    assign mark[MARK_EOF] = last_col && last_row;
    assign sof            = mark[MARK_SOF];
    assign eol            = mark[MARK_EOL];
    assign eof            = mark[MARK_EOF];

    pixel_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pixel_in),
        .dout  (pixel_out),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // frame position advances only on a transferred beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
        end
    end

    // sticky drop flag and end-of-frame pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            overflow   <= overflow | (valid_in && full && !pop);
            frame_done <= pop && eof;
        end
    end

`ifdef PIXEL_FRAME_PACKER_CHECKSUM_EN
    logic [15:0] acc;

    // running frame sum, published and cleared on the eof beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            checksum <= '0;
        end else if (pop) begin
            if (eof) begin
                checksum <= acc + 16'(pixel_out);
                acc      <= '0;
            end else begin
                acc <= acc + 16'(pixel_out);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_frame_packer.sv
// tb_pixel_frame_packer: scoreboard bench with a queue-based reference model of the packer
module tb_pixel_frame_packer;

    localparam int W = 8;
    localparam int H = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b0;
    logic [7:0] pixel_out;
    logic       valid_out, sof, eol, eof, frame_done, overflow;
    logic [2:0] level;
`ifdef PIXEL_FRAME_PACKER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pixel_frame_packer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .pixel_out  (pixel_out),
        .valid_out  (valid_out),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .frame_done (frame_done),
        .overflow   (overflow),
        .level      (level)
`ifdef PIXEL_FRAME_PACKER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: a queue of buffered pixels and a count of transferred beats
    logic [7:0]  mq[$];
    int          pops = 0;
    logic        m_ovf = 1'b0;
    logic        m_fd = 1'b0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_ck = '0;

    always @(negedge clk) begin
        int  idx;
        bit  pop, was_full, e_sof, e_eol, e_eof;
        if (!rst) begin
            mq.delete();
            pops  = 0;
            m_ovf = 1'b0;
            m_fd  = 1'b0;
            m_acc = '0;
            m_ck  = '0;
            chk("rst_valid", 32'(valid_out), 0);
            chk("rst_level", 32'(level), 0);
            chk("rst_pixel", 32'(pixel_out), 0);
        end else begin
            idx   = pops % (W * H);
            e_sof = idx == 0;
            e_eol = (idx % W) == W - 1;
            e_eof = idx == W * H - 1;
            chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
            chk("level", 32'(level), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
`ifdef PIXEL_FRAME_PACKER_CHECKSUM_EN
            chk("checksum", 32'(checksum), 32'(m_ck));
`endif
            if (mq.size() != 0) begin
                chk("pixel_out", 32'(pixel_out), 32'(mq[0]));
                chk("sof", 32'(sof), 32'(e_sof));
                chk("eol", 32'(eol), 32'(e_eol));
                chk("eof", 32'(eof), 32'(e_eof));
            end
            was_full = mq.size() == D;
            pop      = mq.size() != 0 && ready_in;
            m_fd     = pop && e_eof;
            if (pop) begin
                if (e_eof) begin
                    m_ck  = m_acc + 16'(mq[0]);
                    m_acc = '0;
                end else begin
                    m_acc = m_acc + 16'(mq[0]);
                end
                pops++;
                void'(mq.pop_front());
            end
            if (valid_in) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else mq.push_back(pixel_in);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] p, input logic r);
        valid_in = v;
        pixel_in = p;
        ready_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    // assert reset between clock edges and confirm it takes effect without a clock
    task automatic async_reset();
        valid_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(valid_out), 0);
        chk("async_level", 32'(level), 0);
        chk("async_overflow", 32'(overflow), 0);
        chk("async_frame_done", 32'(frame_done), 0);
        chk("async_pixel", 32'(pixel_out), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b1);
        idle(4);
        chk("stream_no_overflow", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        chk("full_level", 32'(level), 4);
        step(1'b1, 8'hAA, 1'b1);
        chk("full_pop_push_level", 32'(level), 4);
        chk("full_pop_push_ovf", 32'(overflow), 0);
        idle(6);
        step(1'b1, 8'h5C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("stall_pixel", 32'(pixel_out), 32'h5C);
        end
        idle(3);
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        idle(6);
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_set", 32'(overflow), 1);
        idle(8);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_drained", 32'(level), 0);
        async_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'h40 + 8'(i), 1'b1);
        async_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b1);
        idle(4);
`ifdef PIXEL_FRAME_PACKER_CHECKSUM_EN
        async_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) step(1'b1, 8'hFF, 1'b1);
            idle(3);
            chk("checksum_frame", 32'(checksum), 32'h3FC0);
        end
`endif
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_frame_packer.md
Name: pixel_frame_packer

Overview:
- Downstream stage of image_inversion. Consumes its pixel_out/valid_out stream, which has no backpressure.
- Buffers pixels in a small FIFO and re-emits them with a ready/valid handshake.
- Tags each output beat with frame position markers (sof, eol, eof) so the writer/display stage can frame an IMG_W x IMG_H image.
- Flags a dropped pixel with a sticky overflow bit.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 8, pixels per line
- IMG_H, 8, lines per frame
- FIFO_DEPTH, 4, buffer entries; power of two, minimum 2

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- pixel_in  input  DATA_W  pixel from image_inversion
- valid_in  input  1  pixel_in valid this cycle; always accepted, never stalled
- ready_in  input  1  downstream able to take a beat
- pixel_out  output  DATA_W  buffered pixel
- valid_out  output  1  pixel_out valid
- sof  output  1  beat is pixel (0,0); qualified by valid_out
- eol  output  1  beat is last pixel of a line; qualified by valid_out
- eof  output  1  beat is last pixel of the frame; qualified by valid_out
- frame_done  output  1  one-cycle pulse, the cycle after the eof beat transfers
- overflow  output  1  sticky; set when a pixel is dropped
- level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, level=0, valid_out=0, col=0, row=0, overflow=0, frame_done=0. pixel_out is held at 0.
- Push: occurs on every cycle where valid_in=1 and either the FIFO is not full or a pop happens in the same cycle.
- Pop: occurs when valid_out=1 and ready_in=1.
- Full with simultaneous push and pop: the write is accepted and level is unchanged.
- Full with push and no pop: the pixel is dropped, overflow is set to 1 and stays set until reset. FIFO contents are unchanged.
- Empty with push and no pop: level becomes 1. There is no same-cycle bypass.
- Latency: a pixel pushed in cycle N is visible on pixel_out/valid_out in cycle N+1 at the earliest.
- Output is first-word-fall-through: valid_out = (level != 0), and pixel_out = the head entry.
- pixel_out/valid_out hold stable while valid_out=1 and ready_in=0.
- Read and write pointers are clog2(FIFO_DEPTH) bits and wrap naturally. level is tracked separately so the full and empty states are distinct.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on a pop.
  - On a pop with col=IMG_W-1: col goes to 0 and row increments.
  - On a pop with col=IMG_W-1 and row=IMG_H-1: both go to 0.
- Markers are combinational from the counters and are meaningful only when valid_out=1:
  - sof = (col==0 && row==0)
  - eol = (col==IMG_W-1)
  - eof = eol && (row==IMG_H-1)
- frame_done is registered: it is high exactly one cycle after a pop in which eof=1.
- Dropped pixels do not advance the counters. Frame alignment after an overflow is not recovered; it is restored only by reset.
- Reset asserted mid-frame discards the buffered pixels and the position. After release, the next popped pixel carries sof=1.

Optional Feature:
- Macro: PIXEL_FRAME_PACKER_CHECKSUM_EN
- When defined:
  - Adds output port checksum [15:0].
  - A 16-bit accumulator adds each popped pixel, zero-extended, modulo 2^16.
  - On the eof pop, checksum is loaded with accumulator+pixel and the accumulator clears to 0. checksum holds until the next eof pop.
  - Both the accumulator and checksum reset to 0.
- When not defined: the port, the accumulator and the checksum logic are absent. All other behaviour is identical.

Decomposition:
- Shared package pixel_pkg holds:
  - default DATA_W/IMG_W/IMG_H constants shared with image_inversion
  - clog2 helper function
  - marker bit-index constants (SOF/EOL/EOF)
- One natural sub-module: pixel_sync_fifo (DATA_W, FIFO_DEPTH). It provides push/pop/full/empty/level and contains no frame logic.
- pixel_frame_packer owns the counters, markers, overflow and the optional checksum.

Test Plan:
- Reset/no backpressure: hold ready_in=1 and stream 64 pixels 0x00..0x3F with valid_in=1, for IMG_W=IMG_H=8.
  - Outputs are 0x00..0x3F in order, each one cycle after input.
  - sof only on 0x00; eol on 0x07, 0x0F, …, 0x3F; eof only on 0x3F.
  - frame_done pulses once, one cycle later.
  - overflow stays 0.
- Full with concurrent pop: fill the FIFO with 4 pixels (ready_in=0), then drive ready_in=1 and push 0xAA in the same cycle.
  - level stays 4, no drop, overflow=0.
  - 0xAA emerges fifth.
- Overflow: ready_in=0 and push 5 pixels 0x10..0x14.
  - level=4 and overflow=1 from the cycle after 0x14.
  - Draining yields 0x10..0x13 only.
  - overflow remains 1 until rst=0.
- Stall stability: set ready_in=0 for 3 cycles with valid_out=1 and head=0x5C.
  - pixel_out=0x5C, valid_out=1 and the markers are unchanged throughout.
  - No counter advance.
- Mid-frame reset: after 20 popped pixels, pulse rst=0 asynchronously (not clock-aligned), then stream 0x80…
  - All outputs return to reset values immediately.
  - The first post-reset output 0x80 has sof=1.
- Checksum (macro defined): stream 64 pixels of value 0xFF.
  - After the eof pop, checksum = 0x3FC0.
  - A second identical frame yields 0x3FC0 again, confirming the accumulator clears.
